glitch_monitor: RTL and testbench

- Clocked observer for the far end of a gate-level hazard circuit, whose output is nominally static at a known idle level.
- Synchronises the asynchronous monitored line and detects every excursion away from the idle level.
- Measures each excursion's width in clock cycles and reports it over a valid/ready event interface.
- Keeps a saturating event count and a sticky overflow flag. Used on lab benches to quantify static hazards produced by the combinational blocks.

---
 rtl/glitch_monitor_pkg.sv | 13 +
 rtl/glitch_sync.sv | 27 ++
 rtl/glitch_monitor.sv | 151 +++++++++++++++
 tb/tb_glitch_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_monitor_pkg.sv
// Shared definitions for the glitch monitor: FSM state encoding and default sizing.
package glitch_monitor_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    localparam int WIDTH_W_DEF     = 8;
    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/glitch_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit line, preset to a known level on reset.
module glitch_sync
    import glitch_monitor_pkg::*;
#(
    parameter int   STAGES = SYNC_STAGES_DEF,
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Preset avoids a phantom excursion right after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{PRESET}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/glitch_monitor.sv
// Measures excursions of a static line away from its idle level and reports them as events.
// Optional macro GLITCH_MONITOR_TSTAMP_EN adds a start-of-excursion timestamp output.
module glitch_monitor
    import glitch_monitor_pkg::*;
#(
    parameter int   WIDTH_W     = WIDTH_W_DEF,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mon_in,
    input  logic               clr_count,
    input  logic               evt_ready,
    output logic               evt_valid,
    output logic [WIDTH_W-1:0] evt_width,
    output logic [CNT_W-1:0]   evt_count,
    output logic               overflow,
    output logic               busy
`ifdef GLITCH_MONITOR_TSTAMP_EN
    ,
    output logic [CNT_W-1:0]   evt_tstamp
`endif
);

    function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
        return (&v) ? v : v + WIDTH_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_count(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic               s;
    logic               deviant;
    state_t             state;
    state_t             state_nxt;
    logic [WIDTH_W-1:0] width;
    logic [WIDTH_W-1:0] width_nxt;
    logic               pulse_end;
    logic               load;
    logic               drop;

    glitch_sync #(
        .STAGES (SYNC_STAGES),
        .PRESET (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (mon_in),
        .q   (s)
    );

    assign deviant = (s != IDLE_LEVEL);
    assign busy    = (state == ST_PULSE);

    always_comb begin
        state_nxt = state;
        width_nxt = width;
        pulse_end = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (deviant) begin
                        state_nxt = ST_PULSE;
                        width_nxt = WIDTH_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (deviant) begin
                        width_nxt = sat_inc_width(width);
                    end else begin
                        state_nxt = ST_IDLE;
                        pulse_end = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A pending record blocks a new one unless it is being accepted this same cycle.
    assign load = pulse_end && (!evt_valid || evt_ready);
    assign drop = pulse_end && evt_valid && !evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            width <= '0;
        end else begin
            state <= state_nxt;
            width <= width_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_width <= '0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_width <= width;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    // Clear takes priority over a simultaneous increment or drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else if (clr_count) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pulse_end) begin
                evt_count <= sat_inc_count(evt_count);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef GLITCH_MONITOR_TSTAMP_EN
    logic [CNT_W-1:0] tstamp_ctr;
    logic [CNT_W-1:0] tstamp_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstamp_ctr <= '0;
            tstamp_cap <= '0;
            evt_tstamp <= '0;
        end else begin
            tstamp_ctr <= tstamp_ctr + CNT_W'(1);
            if (state == ST_IDLE && state_nxt == ST_PULSE) begin
                tstamp_cap <= tstamp_ctr;
            end
            if (load) begin
                evt_tstamp <= tstamp_cap;
            end
        end
    end
`endif

endmodule

// File: tb/tb_glitch_monitor.sv
// Scoreboard bench for glitch_monitor: directed excursions, handshake, overflow, enable and reset cases.
module tb_glitch_monitor;

    localparam int WIDTH_W = 8;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               mon_in;
    logic               clr_count;
    logic               evt_ready;
    logic               evt_valid;
    logic [WIDTH_W-1:0] evt_width;
    logic [CNT_W-1:0]   evt_count;
    logic               overflow;
    logic               busy;
`ifdef GLITCH_MONITOR_TSTAMP_EN
    logic [CNT_W-1:0]   evt_tstamp;
`endif

    int checks = 0;
    int errors = 0;
    int sb[$];

    glitch_monitor #(
        .WIDTH_W     (WIDTH_W),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mon_in    (mon_in),
        .clr_count (clr_count),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_width (evt_width),
        .evt_count (evt_count),
        .overflow  (overflow),
        .busy      (busy)
`ifdef GLITCH_MONITOR_TSTAMP_EN
        ,
        .evt_tstamp (evt_tstamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted record is matched against the next expected width.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got width %0d expected no event at %0t", evt_width, $time);
                end else begin
                    check("evt_width", 32'(evt_width), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        clk       = 1'b0;
        rst       = 1'b1;
        enable    = 1'b1;
        mon_in    = 1'b1;
        clr_count = 1'b0;
        evt_ready = 1'b0;
        #2;
        check("reset_valid", 32'(evt_valid), 0);
        check("reset_count", 32'(evt_count), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_overflow", 32'(overflow), 0);
        tick(3);
        rst = 1'b0;
        tick(10);
        check("idle_valid", 32'(evt_valid), 0);
        check("idle_count", 32'(evt_count), 0);
        check("idle_busy", 32'(busy), 0);

        // 3-cycle low with consumer ready
        evt_ready = 1'b1;
        sb.push_back(3);
        mon_in = 1'b0;
        tick(3);
        mon_in = 1'b1;
        tick(2);
        check("p3_busy_before_end", 32'(busy), 1);
        check("p3_valid_before_end", 32'(evt_valid), 0);
        tick(1);
        check("p3_valid", 32'(evt_valid), 1);
        check("p3_width", 32'(evt_width), 3);
        check("p3_busy", 32'(busy), 0);
        check("p3_count", 32'(evt_count), 1);
        tick(1);
        check("p3_valid_after_accept", 32'(evt_valid), 0);

        // Two 2-cycle lows, consumer stalled: second is dropped
        evt_ready = 1'b0;
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        check("clr1_count", 32'(evt_count), 0);
        mon_in = 1'b0;
        tick(2);
        mon_in = 1'b1;
        tick(1);
        mon_in = 1'b0;
        tick(2);
        mon_in = 1'b1;
        tick(8);
        check("b2b_valid", 32'(evt_valid), 1);
        check("b2b_width", 32'(evt_width), 2);
        check("b2b_overflow", 32'(overflow), 1);
        check("b2b_count", 32'(evt_count), 2);
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        check("clr2_count", 32'(evt_count), 0);
        check("clr2_overflow", 32'(overflow), 0);
        check("clr2_valid", 32'(evt_valid), 1);
        check("clr2_width", 32'(evt_width), 2);
        sb.push_back(2);
        evt_ready = 1'b1;
        tick(2);
        check("b2b_drained", 32'(evt_valid), 0);

        // 300-cycle low saturates the width
        sb.push_back(255);
        mon_in = 1'b0;
        tick(300);
        mon_in = 1'b1;
        tick(8);
        check("sat_count", 32'(evt_count), 1);
        check("sat_valid", 32'(evt_valid), 0);

        // Enable dropped mid-excursion
        mon_in = 1'b0;
        tick(4);
        check("en_busy_in_pulse", 32'(busy), 1);
        enable = 1'b0;
        tick(1);
        check("en_busy_after_disable", 32'(busy), 0);
        mon_in = 1'b1;
        tick(6);
        enable = 1'b1;
        tick(4);
        check("en_count", 32'(evt_count), 1);
        check("en_valid", 32'(evt_valid), 0);
        check("en_busy", 32'(busy), 0);

        // Reset mid-pulse with a pending record
        evt_ready = 1'b0;
        mon_in = 1'b0;
        tick(2);
        mon_in = 1'b1;
        tick(6);
        check("rst_pending_valid", 32'(evt_valid), 1);
        mon_in = 1'b0;
        tick(4);
        check("rst_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_width", 32'(evt_width), 0);
        check("rst_count", 32'(evt_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        mon_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("post_rst_valid", 32'(evt_valid), 0);
        check("post_rst_count", 32'(evt_count), 0);
        check("post_rst_busy", 32'(busy), 0);

        // Pulse end coinciding with acceptance of the pending record
        mon_in = 1'b0;
        tick(2);
        mon_in = 1'b1;
        tick(6);
        sb.push_back(2);
        sb.push_back(3);
        mon_in = 1'b0;
        tick(3);
        mon_in = 1'b1;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        check("coinc_valid", 32'(evt_valid), 1);
        check("coinc_width", 32'(evt_width), 3);
        check("coinc_overflow", 32'(overflow), 0);
        check("coinc_count", 32'(evt_count), 2);
        tick(1);
        check("coinc_drained", 32'(evt_valid), 0);

        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 50) begin
            tick(1);
            wait_cycles++;
        end
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
